// File: rtl/ir_calc_controller_pkg.sv
// Shared constants, state encoding and helpers for the IR-remote calculator sequencer.
package ir_calc_controller_pkg;

  localparam logic [7:0] K_PWR     = 8'h12;
  localparam logic [7:0] K_CLR_A   = 8'h0F;
  localparam logic [7:0] K_CLR_B   = 8'h13;
  localparam logic [7:0] K_CLR_ALL = 8'h10;
  localparam logic [7:0] K_ADD     = 8'h1A;
  localparam logic [7:0] K_SUB     = 8'h1E;
  localparam logic [7:0] K_SIGN    = 8'h0C;
  localparam logic [7:0] K_SEL     = 8'h15;

  localparam int unsigned HOLDOFF_CYC_DEF = 25_000_000;

  localparam logic [3:0] BLANK   = 4'hF;
  localparam logic [6:0] SAT_MAG = 7'd99;

  typedef enum logic [2:0] {
    S_OFF,
    S_IDLE,
    S_CALC,
    S_CONV,
    S_WB
  } state_e;

  function automatic logic is_digit(input logic [7:0] c);
    return c <= 8'h09;
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] u);
    return 7'(t) * 7'd10 + 7'(u);
  endfunction

endpackage

// File: rtl/ir_calc_controller_if.sv
// Command byte handshake from the IR decoder into the calculator sequencer.
interface ir_calc_controller_if;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/ir_calc_controller_bin2bcd_seq.sv
// Sequential binary-to-BCD converter for 0..99: subtracts 10 once per cycle,
// so it needs floor(mag/10)+1 cycles after start before done pulses.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [6:0] mag_i,
  output logic       done_o,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  logic [6:0] rem_q, rem_d;
  logic [3:0] tens_q, tens_d;
  logic       run_q, run_d;

  always_comb begin
    rem_d  = rem_q;
    tens_d = tens_q;
    run_d  = run_q;
    if (start_i) begin
      rem_d  = mag_i;
      tens_d = 4'd0;
      run_d  = 1'b1;
    end else if (run_q) begin
      if (rem_q >= 7'd10) begin
        rem_d  = rem_q - 7'd10;
        tens_d = tens_q + 4'd1;
      end else begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= 7'd0;
      tens_q <= 4'd0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      tens_q <= tens_d;
      run_q  <= run_d;
    end
  end

  // The remainder is below ten exactly on the last running cycle.
  assign done_o  = run_q && (rem_q < 7'd10);
  assign tens_o  = tens_q;
  assign units_o = rem_q[3:0];

endmodule

// File: rtl/ir_calc_controller.sv
// IR-remote calculator sequencer: power, two signed BCD operands, add/sub with saturation.
// Optional repeat suppression of identical commands is enabled by defining CALC_HOLDOFF_EN.
module ir_calc_controller
  import ir_calc_controller_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  ir_calc_controller_if.slave  cmd_if,
  output logic                 pwr_on_o,
  output logic                 sel_b_o,
  output logic                 a_neg_o,
  output logic [3:0]           a_tens_o,
  output logic [3:0]           a_units_o,
  output logic                 b_neg_o,
  output logic [3:0]           b_tens_o,
  output logic [3:0]           b_units_o,
  output logic                 ovf_o,
  output logic                 busy_o
);

`ifdef CALC_HOLDOFF_EN
  parameter int unsigned HOLDOFF_CYC = HOLDOFF_CYC_DEF;
`endif

  state_e     state_q, state_d;
  logic       pwr_q, pwr_d;
  logic       sel_b_q, sel_b_d;
  logic       a_neg_q, a_neg_d;
  logic [3:0] a_tens_q, a_tens_d;
  logic [3:0] a_units_q, a_units_d;
  logic       b_neg_q, b_neg_d;
  logic [3:0] b_tens_q, b_tens_d;
  logic [3:0] b_units_q, b_units_d;
  logic       ovf_q, ovf_d;
  logic       busy_q, busy_d;
  logic       op_sub_q, op_sub_d;
  logic       res_neg_q, res_neg_d;
  logic [6:0] res_mag_q, res_mag_d;

  logic       accept;
  logic       suppress;
  logic       act;

  assign cmd_if.cmd_ready = (state_q == S_OFF) || (state_q == S_IDLE);
  assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign act              = accept && !suppress;

`ifdef CALC_HOLDOFF_EN
  logic [31:0] hold_cnt_q;
  logic [7:0]  last_cmd_q;

  assign suppress = (hold_cnt_q != 32'd0) && (cmd_if.cmd == last_cmd_q);

  // The window restarts on every accept, including suppressed repeats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= 32'd0;
      last_cmd_q <= 8'd0;
    end else if (accept) begin
      hold_cnt_q <= HOLDOFF_CYC;
      last_cmd_q <= cmd_if.cmd;
    end else if (hold_cnt_q != 32'd0) begin
      hold_cnt_q <= hold_cnt_q - 32'd1;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  logic [7:0] va, vb;
  logic [8:0] r, r_abs;
  logic       sat;
  logic [6:0] calc_mag;
  logic       conv_done;
  logic [3:0] conv_tens, conv_units;

  // Signed operand values in two's complement; result range is -198..198.
  always_comb begin
    va       = a_neg_q ? -{1'b0, bcd_to_bin(a_tens_q, a_units_q)} : {1'b0, bcd_to_bin(a_tens_q, a_units_q)};
    vb       = b_neg_q ? -{1'b0, bcd_to_bin(b_tens_q, b_units_q)} : {1'b0, bcd_to_bin(b_tens_q, b_units_q)};
    r        = op_sub_q ? ({va[7], va} - {vb[7], vb}) : ({va[7], va} + {vb[7], vb});
    r_abs    = r[8] ? -r : r;
    sat      = r_abs > 9'd99;
    calc_mag = sat ? SAT_MAG : r_abs[6:0];
  end

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (state_q == S_CALC),
    .mag_i   (calc_mag),
    .done_o  (conv_done),
    .tens_o  (conv_tens),
    .units_o (conv_units)
  );

  always_comb begin
    state_d   = state_q;
    pwr_d     = pwr_q;
    sel_b_d   = sel_b_q;
    a_neg_d   = a_neg_q;
    a_tens_d  = a_tens_q;
    a_units_d = a_units_q;
    b_neg_d   = b_neg_q;
    b_tens_d  = b_tens_q;
    b_units_d = b_units_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    op_sub_d  = op_sub_q;
    res_neg_d = res_neg_q;
    res_mag_d = res_mag_q;

    case (state_q)
      S_OFF: begin
        if (act && (cmd_if.cmd == K_PWR)) begin
          state_d   = S_IDLE;
          pwr_d     = 1'b1;
          sel_b_d   = 1'b0;
          a_neg_d   = 1'b0;
          a_tens_d  = 4'd0;
          a_units_d = 4'd0;
          b_neg_d   = 1'b0;
          b_tens_d  = 4'd0;
          b_units_d = 4'd0;
          ovf_d     = 1'b0;
        end
      end

      S_IDLE: begin
        if (act) begin
          if (is_digit(cmd_if.cmd)) begin
            if (sel_b_q) begin
              b_tens_d  = b_units_q;
              b_units_d = cmd_if.cmd[3:0];
            end else begin
              a_tens_d  = a_units_q;
              a_units_d = cmd_if.cmd[3:0];
            end
          end else begin
            case (cmd_if.cmd)
              K_SEL:  sel_b_d = !sel_b_q;
              K_SIGN: begin
                if (sel_b_q) b_neg_d = !b_neg_q;
                else         a_neg_d = !a_neg_q;
              end
              K_CLR_A: begin
                a_neg_d   = 1'b0;
                a_tens_d  = 4'd0;
                a_units_d = 4'd0;
              end
              K_CLR_B: begin
                b_neg_d   = 1'b0;
                b_tens_d  = 4'd0;
                b_units_d = 4'd0;
              end
              K_CLR_ALL: begin
                a_neg_d   = 1'b0;
                a_tens_d  = 4'd0;
                a_units_d = 4'd0;
                b_neg_d   = 1'b0;
                b_tens_d  = 4'd0;
                b_units_d = 4'd0;
                sel_b_d   = 1'b0;
                ovf_d     = 1'b0;
              end
              K_PWR: begin
                state_d   = S_OFF;
                pwr_d     = 1'b0;
                sel_b_d   = 1'b0;
                a_neg_d   = 1'b0;
                a_tens_d  = BLANK;
                a_units_d = BLANK;
                b_neg_d   = 1'b0;
                b_tens_d  = BLANK;
                b_units_d = BLANK;
                ovf_d     = 1'b0;
              end
              K_ADD, K_SUB: begin
                op_sub_d = (cmd_if.cmd == K_SUB);
                busy_d   = 1'b1;
                state_d  = S_CALC;
              end
              default: ;
            endcase
          end
        end
      end

      S_CALC: begin
        res_neg_d = r[8];
        res_mag_d = calc_mag;
        ovf_d     = sat;
        state_d   = S_CONV;
      end

      S_CONV: begin
        if (conv_done) state_d = S_WB;
      end

      // A zero result never shows as negative.
      S_WB: begin
        a_tens_d  = conv_tens;
        a_units_d = conv_units;
        a_neg_d   = res_neg_q && (res_mag_q != 7'd0);
        b_neg_d   = 1'b0;
        b_tens_d  = 4'd0;
        b_units_d = 4'd0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end

      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_OFF;
      pwr_q     <= 1'b0;
      sel_b_q   <= 1'b0;
      a_neg_q   <= 1'b0;
      a_tens_q  <= BLANK;
      a_units_q <= BLANK;
      b_neg_q   <= 1'b0;
      b_tens_q  <= BLANK;
      b_units_q <= BLANK;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      op_sub_q  <= 1'b0;
      res_neg_q <= 1'b0;
      res_mag_q <= 7'd0;
    end else begin
      state_q   <= state_d;
      pwr_q     <= pwr_d;
      sel_b_q   <= sel_b_d;
      a_neg_q   <= a_neg_d;
      a_tens_q  <= a_tens_d;
      a_units_q <= a_units_d;
      b_neg_q   <= b_neg_d;
      b_tens_q  <= b_tens_d;
      b_units_q <= b_units_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      op_sub_q  <= op_sub_d;
      res_neg_q <= res_neg_d;
      res_mag_q <= res_mag_d;
    end
  end

  assign pwr_on_o  = pwr_q;
  assign sel_b_o   = sel_b_q;
  assign a_neg_o   = a_neg_q;
  assign a_tens_o  = a_tens_q;
  assign a_units_o = a_units_q;
  assign b_neg_o   = b_neg_q;
  assign b_tens_o  = b_tens_q;
  assign b_units_o = b_units_q;
  assign ovf_o     = ovf_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_ir_calc_controller.sv
// Directed bench for ir_calc_controller with a behavioural model and a result scoreboard.
module tb_ir_calc_controller;
  import ir_calc_controller_pkg::*;

`ifdef CALC_HOLDOFF_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  localparam longint HOLD_T = 100 * 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwr_on, sel_b, a_neg, b_neg, ovf, busy;
  logic [3:0] a_tens, a_units, b_tens, b_units;

  always #5 clk = ~clk;

  ir_calc_controller_if itf ();

`ifdef CALC_HOLDOFF_EN
  ir_calc_controller #(.HOLDOFF_CYC(100)) dut (
`else
  ir_calc_controller dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_if    (itf.slave),
    .pwr_on_o  (pwr_on),
    .sel_b_o   (sel_b),
    .a_neg_o   (a_neg),
    .a_tens_o  (a_tens),
    .a_units_o (a_units),
    .b_neg_o   (b_neg),
    .b_tens_o  (b_tens),
    .b_units_o (b_units),
    .ovf_o     (ovf),
    .busy_o    (busy)
  );

  typedef struct packed {
    logic       aNeg;
    logic [3:0] aT;
    logic [3:0] aU;
    logic       ovf;
    logic [7:0] lat;
  } exp_t;

  exp_t   sbq[$];
  int     checks = 0;
  int     errors = 0;

  // Reference model state, derived from the calculator's intended behaviour.
  bit     mPwr, mSel, mANeg, mBNeg, mOvf;
  int     mA, mB;
  int     lastCmd;
  longint lastT;

  task automatic modelReset();
    mPwr = 0; mSel = 0; mANeg = 0; mBNeg = 0; mOvf = 0;
    mA = 0; mB = 0;
    lastCmd = -1; lastT = -1000000;
  endtask

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] digOf(input int v, input bit tensPos);
    if (!mPwr) return 8'h0F;
    return tensPos ? 8'(v / 10) : 8'(v % 10);
  endfunction

  task automatic checkOutput(input string ctx);
    checkVal({ctx, ".pwr_on"},    {7'd0, pwr_on},        {7'd0, mPwr});
    checkVal({ctx, ".sel_b"},     {7'd0, sel_b},         {7'd0, mSel});
    checkVal({ctx, ".a_neg"},     {7'd0, a_neg},         {7'd0, mANeg});
    checkVal({ctx, ".a_tens"},    {4'd0, a_tens},        digOf(mA, 1'b1));
    checkVal({ctx, ".a_units"},   {4'd0, a_units},       digOf(mA, 1'b0));
    checkVal({ctx, ".b_neg"},     {7'd0, b_neg},         {7'd0, mBNeg});
    checkVal({ctx, ".b_tens"},    {4'd0, b_tens},        digOf(mB, 1'b1));
    checkVal({ctx, ".b_units"},   {4'd0, b_units},       digOf(mB, 1'b0));
    checkVal({ctx, ".ovf"},       {7'd0, ovf},           {7'd0, mOvf});
    checkVal({ctx, ".busy"},      {7'd0, busy},          8'd0);
    checkVal({ctx, ".cmd_ready"}, {7'd0, itf.cmd_ready}, 8'd1);
  endtask

  task automatic sendCmd(input logic [7:0] c);
    itf.cmd       = c;
    itf.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    itf.cmd_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic noteAccept(input logic [7:0] c, output bit ign);
    longint edgeT;
    edgeT   = longint'($time) + 9;
    ign     = HOLD_EN && (int'(c) == lastCmd) && ((edgeT - lastT) <= HOLD_T);
    lastCmd = int'(c);
    lastT   = edgeT;
  endtask

  task automatic modelCmd(input logic [7:0] c);
    if (!mPwr) begin
      if (c == K_PWR) begin
        mPwr = 1; mSel = 0; mANeg = 0; mBNeg = 0; mOvf = 0; mA = 0; mB = 0;
      end
    end else if (c <= 8'h09) begin
      if (mSel) mB = (mB % 10) * 10 + int'(c);
      else      mA = (mA % 10) * 10 + int'(c);
    end else begin
      case (c)
        K_SEL:     mSel = !mSel;
        K_SIGN:    if (mSel) mBNeg = !mBNeg; else mANeg = !mANeg;
        K_CLR_A:   begin mA = 0; mANeg = 0; end
        K_CLR_B:   begin mB = 0; mBNeg = 0; end
        K_CLR_ALL: begin mA = 0; mB = 0; mANeg = 0; mBNeg = 0; mSel = 0; mOvf = 0; end
        K_PWR:     begin mPwr = 0; mSel = 0; mANeg = 0; mBNeg = 0; mOvf = 0; mA = 0; mB = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic startArith(input logic [7:0] c);
    int   va, vb, r, m;
    exp_t e;
    va = mANeg ? -mA : mA;
    vb = mBNeg ? -mB : mB;
    r  = (c == K_SUB) ? va - vb : va + vb;
    m  = (r < 0) ? -r : r;
    e.ovf = (m > 99);
    if (m > 99) m = 99;
    e.aNeg = (r < 0) && (m != 0);
    e.aT   = 4'(m / 10);
    e.aU   = 4'(m % 10);
    e.lat  = 8'(m / 10 + 3);
    sbq.push_back(e);
    sendCmd(c);
    checkVal("busy_after_accept",  {7'd0, busy},          8'd1);
    checkVal("ready_while_busy",   {7'd0, itf.cmd_ready}, 8'd0);
  endtask

  task automatic finishArith(input int elapsed);
    int   n;
    exp_t e;
    n = elapsed;
    while ((busy === 1'b1) && (n < 200)) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sbq.pop_front();
    checkVal("latency", 8'(n), e.lat);
    mANeg = e.aNeg;
    mA    = int'(e.aT) * 10 + int'(e.aU);
    mB    = 0;
    mBNeg = 0;
    mOvf  = e.ovf;
    checkOutput("arith");
  endtask

  task automatic applyStimulus(input logic [7:0] c);
    bit ign;
    noteAccept(c, ign);
    if (!ign && mPwr && ((c == K_ADD) || (c == K_SUB))) begin
      startArith(c);
      finishArith(0);
    end else begin
      sendCmd(c);
      if (!ign) modelCmd(c);
      checkOutput($sformatf("cmd%02h", c));
    end
  endtask

  initial begin
    bit ign;
    itf.cmd_valid = 1'b0;
    itf.cmd       = 8'h00;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset");
    rst_n = 1'b1;
    idleCycles(1);

    $display("[TB] power toggle");
    applyStimulus(K_PWR);
    idleCycles(110);
    applyStimulus(K_PWR);
    idleCycles(110);
    applyStimulus(K_PWR);

    $display("[TB] entry and add");
    applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03);
    applyStimulus(K_SEL); applyStimulus(8'h04); applyStimulus(8'h05);
    applyStimulus(K_ADD);

    $display("[TB] subtraction and sign");
    applyStimulus(K_CLR_ALL);
    applyStimulus(8'h00); applyStimulus(8'h05);
    applyStimulus(K_SEL); applyStimulus(8'h02); applyStimulus(8'h00);
    applyStimulus(K_SUB);
    applyStimulus(K_SEL); applyStimulus(K_SIGN);
    applyStimulus(K_SUB);
    applyStimulus(K_SEL); applyStimulus(8'h01); applyStimulus(8'h05);
    applyStimulus(K_SUB);

    $display("[TB] saturation");
    applyStimulus(K_CLR_ALL);
    applyStimulus(8'h09); applyStimulus(8'h00);
    applyStimulus(K_SEL); applyStimulus(8'h05); applyStimulus(8'h00);
    applyStimulus(K_ADD);
    applyStimulus(K_SEL); applyStimulus(K_SIGN);
    applyStimulus(K_SEL); applyStimulus(8'h09); applyStimulus(8'h09);
    applyStimulus(K_SUB);
    applyStimulus(K_CLR_ALL);

    $display("[TB] busy drop and mid-conversion reset");
    applyStimulus(8'h06); applyStimulus(8'h08);
    idleCycles(110);
    noteAccept(K_ADD, ign);
    startArith(K_ADD);
    sendCmd(8'h07);
    finishArith(1);
    idleCycles(110);
    noteAccept(K_ADD, ign);
    startArith(K_ADD);
    idleCycles(4);
    rst_n = 1'b0;
    #1;
    void'(sbq.pop_front());
    modelReset();
    checkOutput("mid_conv_reset");
    rst_n = 1'b1;
    idleCycles(1);
    applyStimulus(K_PWR);

`ifdef CALC_HOLDOFF_EN
    $display("[TB] holdoff");
    idleCycles(150);
    applyStimulus(K_CLR_A);
    applyStimulus(8'h03);
    idleCycles(50);
    applyStimulus(8'h03);
    checkVal("holdoff_short", {a_tens, a_units}, 8'h03);
    idleCycles(150);
    applyStimulus(8'h03);
    checkVal("holdoff_long", {a_tens, a_units}, 8'h33);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
